// File: rtl/add_pipe.sv
// Pipelined two's-complement adder/subtractor: the WIDTH-bit add is cut into STAGES
// chunks, with each chunk's carry registered into the next stage; global stall via out_ready.
module add_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int C = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             valid_q;

  assign advance   = !valid_q || out_ready;
  assign in_ready  = advance;
  assign b_eff     = b ^ {WIDTH{sub}};
  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Stage k holds only operand bits not yet summed (R-C wide) plus the finished low sum bits,
  // so register widths shrink/grow exactly as chunks complete.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * C;
    localparam int R  = WIDTH - LO;

    logic [R-1:0]      a_in;
    logic [R-1:0]      b_in;
    logic [LO+C-1:0]   s_all;
    logic              c_in;
    logic              v_in;
    logic [C:0]        chunk;

    assign chunk = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = sub;
      assign v_in  = in_valid;
      assign s_all = chunk[C-1:0];
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_mid.a_q;
      assign b_in  = g_stage[k-1].g_mid.b_q;
      assign c_in  = g_stage[k-1].g_mid.c_q;
      assign v_in  = g_stage[k-1].g_mid.v_q;
      assign s_all = {chunk[C-1:0], g_stage[k-1].g_mid.s_q};
    end

    if (k < STAGES - 1) begin : g_mid
      logic [R-C-1:0]  a_q;
      logic [R-C-1:0]  b_q;
      logic [LO+C-1:0] s_q;
      logic            c_q;
      logic            v_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_in;
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_in[R-1:C];
          b_q <= b_in[R-1:C];
          s_q <= s_all;
          c_q <= chunk[C];
        end
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          sum_q   <= '0;
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          zero_q  <= 1'b0;
        end else if (advance) begin
          valid_q <= v_in;
          sum_q   <= s_all;
          carry_q <= chunk[C];
          ovf_q   <= (a_in[C-1] == b_in[C-1]) && (chunk[C-1] != a_in[C-1]);
          zero_q  <= (s_all == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: 64-bit/4-stage instance for arithmetic, latency, stall and
// reset flush, plus an 8-bit/1-stage instance for the degenerate single-register case.
module tb_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [63:0] a, b, sum;
  logic        carry, ovf, zero;

  logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, sum8;
  logic        carry8, ovf8, zero8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(ovf), .zero(zero)
  );

  add_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry(carry8), .overflow(ovf8), .zero(zero8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after a rising edge with an empty pipe and out_ready=1.
  task automatic beat(input string tag, input logic [63:0] av, input logic [63:0] bv,
                      input logic sv, input logic [63:0] es, input logic ec,
                      input logic ev, input logic ez);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    #1;
    check({tag, ".in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, ".early"}, out_valid, 0);
    tick();
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".sum"}, sum, es);
    check({tag, ".carry"}, carry, ec);
    check({tag, ".ovf"}, ovf, ev);
    check({tag, ".zero"}, zero, ez);
    tick();
    check({tag, ".single"}, out_valid, 0);
  endtask

  logic [63:0] sa [8];
  logic [63:0] sb [8];
  logic        ss [8];
  logic [63:0] se [8];

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int ni;
    int no;

    sa[0] = 64'd1;                  sb[0] = 64'd2;                  ss[0] = 1'b0; se[0] = 64'd3;
    sa[1] = 64'd10;                 sb[1] = 64'd3;                  ss[1] = 1'b1; se[1] = 64'd7;
    sa[2] = 64'h0000_0000_0000_FFFF; sb[2] = 64'd1;                 ss[2] = 1'b0; se[2] = 64'h0000_0000_0001_0000;
    sa[3] = 64'hFFFF_FFFF_0000_0000; sb[3] = 64'h0000_0001_0000_0000; ss[3] = 1'b0; se[3] = 64'h0;
    sa[4] = 64'd100;                sb[4] = 64'd200;                ss[4] = 1'b1; se[4] = 64'hFFFF_FFFF_FFFF_FF9C;
    sa[5] = 64'h1234_5678_9ABC_DEF0; sb[5] = 64'h1111_1111_1111_1111; ss[5] = 1'b0; se[5] = 64'h2345_6789_ABCD_F001;
    sa[6] = 64'h1234_5678_9ABC_DEF0; sb[6] = 64'h1111_1111_1111_1111; ss[6] = 1'b1; se[6] = 64'h0123_4567_89AB_CDDF;
    sa[7] = 64'd0;                  sb[7] = 64'd0;                  ss[7] = 1'b0; se[7] = 64'h0;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.sum", sum, 0);
    check("rst.carry", carry, 0);
    check("rst.ovf", ovf, 0);
    check("rst.zero", zero, 0);
    check("rst.out_valid8", out_valid8, 0);
    out_ready = 1'b1;
    tick();

    beat("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    beat("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    beat("sub_eq", 64'd5, 64'd5, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);
    beat("sub_borrow", 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    beat("add_mid", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    beat("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);

    // 8 back-to-back beats, downstream stalls during cycles 6..9
    ni = 0;
    no = 0;
    for (int cyc = 0; cyc < 40 && no < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 9);
      in_valid  = (ni < 8);
      if (ni < 8) begin
        a = sa[ni]; b = sb[ni]; sub = ss[ni];
      end
      #1;
      if (cyc >= 6 && cyc <= 9) begin
        check($sformatf("stall%0d.in_ready", cyc), in_ready, 0);
        check($sformatf("stall%0d.out_valid", cyc), out_valid, 1);
        check($sformatf("stall%0d.hold", cyc), sum, se[no]);
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream.sum%0d", no), sum, se[no]);
        no++;
      end
      if (in_valid && in_ready) ni++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream.delivered", no, 8);
    check("stream.accepted", ni, 8);
    for (int i = 0; i < 3; i++) begin
      check("stream.no_extra", out_valid, 0);
      tick();
    end

    // reset with three beats in flight plus one presented during reset
    a = 64'h111; b = 64'd1; sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 64'h222; b = 64'd2;
    tick();
    a = 64'h333; b = 64'd3;
    tick();
    a = 64'h444; b = 64'd4; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("flush.out_valid", out_valid, 0);
    check("flush.in_ready", in_ready, 1);
    check("flush.sum", sum, 0);
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("flush.gone", out_valid, 0);
      tick();
    end
    beat("recover", 64'd7, 64'd9, 1'b0, 64'd16, 1'b0, 1'b0, 1'b0);

    // WIDTH=8, STAGES=1
    a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1; in_valid8 = 1'b1;
    #1;
    check("w8.in_ready", in_ready8, 1);
    check("w8.idle", out_valid8, 0);
    tick();
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0;
    check("w8.sub.valid", out_valid8, 1);
    check("w8.sub.sum", sum8, 8'h7F);
    check("w8.sub.carry", carry8, 1);
    check("w8.sub.ovf", ovf8, 1);
    check("w8.sub.zero", zero8, 0);
    tick();
    in_valid8 = 1'b0;
    check("w8.add.valid", out_valid8, 1);
    check("w8.add.sum", sum8, 8'h80);
    check("w8.add.carry", carry8, 0);
    check("w8.add.ovf", ovf8, 1);
    tick();
    check("w8.drain", out_valid8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline segments; legal when STAGES >= 1 and WIDTH % STAGES == 0.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operand beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A, two's complement.
REQ-008 SHALL have port b  input  WIDTH  operand B, two's complement.
REQ-009 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result, low WIDTH bits.
REQ-013 SHALL have port carry  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  signed overflow.
REQ-015 SHALL have port zero  output  1  sum == 0.

Function
REQ-016 SHALL split the datapath into STAGES chunks of C = WIDTH/STAGES bits; stage k adds chunk k using the registered carry from stage k-1 (stage 0 carry-in = sub).
REQ-017 SHALL form effective B as b when sub=0, ~b when sub=1; upper chunks of A, effective B and the sub bit travel delayed in the pipeline until their stage.
REQ-018 SHALL assemble completed low chunks alongside each beat so sum/carry/overflow/zero present one coherent result at the output register.
REQ-019 SHALL compute overflow = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
REQ-020 SHALL have latency exactly STAGES cycles from an accepted input beat (in_valid && in_ready) to out_valid, with no stalls.
REQ-021 SHALL use a global advance = !out_valid || out_ready; all stages, including the per-stage valid bits, shift only when advance is 1.
REQ-022 SHALL drive in_ready = advance (combinational, no dependency on in_valid).
REQ-023 SHALL insert a bubble (stage valid 0) when advance=1 and in_valid=0; bubbles consume no output beat.
REQ-024 SHALL hold sum, carry, overflow, zero and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain one beat per cycle when out_ready is held 1; results leave in acceptance order, none dropped or duplicated.
REQ-026 SHALL, for STAGES=1, reduce to a single registered WIDTH-bit add with latency 1.
REQ-027 SHALL treat operand values as unsigned bit vectors for carry and as signed for overflow; no saturation, results wrap modulo 2^WIDTH.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, clear every stage valid bit; the next cycle out_valid=0 and in_ready=1.
REQ-029 SHALL reset sum to 0, carry to 0, overflow to 0, zero to 0.
REQ-030 SHALL discard all in-flight beats on reset mid-operation; an input beat presented while rst=1 is not accepted.
REQ-031 SHALL need no reset on pure datapath registers other than the output registers in REQ-029.

Verification (WIDTH=64, STAGES=4 unless stated)
REQ-032 SHALL cover add a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, overflow=1, carry=0, zero=0, out_valid 4 cycles after accept.
REQ-033 SHALL cover add a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, carry=1, overflow=0, zero=1 (carry ripples through all 4 stages).
REQ-034 SHALL cover sub a=5, b=5 -> sum=0, carry=1, zero=1, overflow=0; sub a=0, b=1 -> sum=all ones, carry=0, overflow=0.
REQ-035 SHALL cover 8 back-to-back beats with out_ready=0 for cycles 6-9 -> in_ready=0 during stall, output held stable, all 8 results in order, none lost.
REQ-036 SHALL cover rst=1 for one cycle with 3 beats in flight -> next cycle out_valid=0, in_ready=1, none of the 3 results ever appear.
REQ-037 SHALL cover WIDTH=8, STAGES=1: sub a=0x80, b=0x01 -> sum=0x7F, carry=1, overflow=1, latency 1.
